dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 83 ++++++++
 tb/tb_dff_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// Elastic register pipeline with valid/ready handshake, bubble collapse and flush.
// Optional qbar output is present only when DFF_PIPE_QBAR_EN is defined.
module dff_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
`ifdef DFF_PIPE_QBAR_EN
  output logic [WIDTH-1:0] qbar,
`endif
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              accept;

  // adv_i is high unless every stage from i to the output is full and q is stalled;
  // evaluated as a running AND so no vector feeds back on itself.
  always_comb begin : adv_chain
    logic stall;
    adv   = '0;
    stall = !q_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stall                = stall && valid_q[STAGES-1-k];
      adv[STAGES-1-k]      = !stall;
    end
  end

  assign d_ready = adv[0] && !flush;
  assign accept  = d_valid && d_ready;

  always_comb begin
    data_d[0]  = adv[0] ? d : data_q[0];
    valid_d[0] = adv[0] ? accept : valid_q[0];
    for (int unsigned i = 1; i < STAGES; i++) begin
      data_d[i]  = adv[i] ? data_q[i-1]  : data_q[i];
      valid_d[i] = adv[i] ? valid_q[i-1] : valid_q[i];
    end
    if (flush) begin
      valid_d = '0;
    end
    count_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      count_d = count_d + CW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign q       = data_q[STAGES-1];
  assign q_valid = valid_q[STAGES-1];
  assign count   = count_q;

`ifdef DFF_PIPE_QBAR_EN
  assign qbar = ~q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed table, corner sequences and a
// randomized run against a beat-position queue model.
module tb_dff_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 4;
  localparam int CW     = $clog2(STAGES + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic             flush;
  logic [WIDTH-1:0] q;
`ifdef DFF_PIPE_QBAR_EN
  logic [WIDTH-1:0] qbar;
`endif
  logic             q_valid;
  logic             q_ready;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  dff_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .flush   (flush),
    .q       (q),
`ifdef DFF_PIPE_QBAR_EN
    .qbar    (qbar),
`endif
    .q_valid (q_valid),
    .q_ready (q_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_qbar(input string name);
`ifdef DFF_PIPE_QBAR_EN
    chk(name, 64'(qbar), 64'(~q));
`endif
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic dv, input logic [WIDTH-1:0] dd, input logic qr, input logic fl);
    @(negedge clk);
    d_valid = dv;
    d       = dd;
    q_ready = qr;
    flush   = fl;
    #1;
  endtask

  typedef struct {
    logic             dv;
    logic [WIDTH-1:0] dd;
    logic             qr;
    logic             fl;
    logic             e_rdy;
    logic             e_qv;
    logic [WIDTH-1:0] e_q;
    logic [CW-1:0]    e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic [WIDTH-1:0] dd, input logic qr,
                              input logic fl, input logic e_rdy, input logic e_qv,
                              input logic [WIDTH-1:0] e_q, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.dv = dv; v.dd = dd; v.qr = qr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_qv = e_qv; v.e_q = e_q; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Reference model: ordered queue of beats, each tagged with its stage index.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } beat_t;
  beat_t mq[$];

  // Lowest stage index still blocked after all beats move; stage 0 is free if >= 0.
  function automatic int model_free(input logic qr);
    int lim;
    int np;
    lim = qr ? STAGES : STAGES - 1;
    foreach (mq[j]) begin
      np  = (mq[j].pos + 1 > lim) ? lim : mq[j].pos + 1;
      lim = np - 1;
    end
    return lim;
  endfunction

  task automatic model_commit(input logic dv, input logic [WIDTH-1:0] dd, input logic qr, input logic fl);
    beat_t nq[$];
    beat_t b;
    int    lim;
    int    np;
    if (fl) begin
      mq.delete();
      return;
    end
    lim = qr ? STAGES : STAGES - 1;
    foreach (mq[j]) begin
      np  = (mq[j].pos + 1 > lim) ? lim : mq[j].pos + 1;
      lim = np - 1;
      if (np < STAGES) begin
        b.data = mq[j].data;
        b.pos  = np;
        nq.push_back(b);
      end
    end
    if (dv && lim >= 0) begin
      b.data = dd;
      b.pos  = 0;
      nq.push_back(b);
    end
    mq = nq;
  endtask

  vec_t tbl[19];

  initial begin
    logic             e_rdy;
    logic             e_qv;
    logic             r_dv;
    logic             r_qr;
    logic             r_fl;
    logic [WIDTH-1:0] r_d;

    tbl[0]  = mk(1, 8'hA5, 1, 0, 1, 0, 8'h00, 0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
    tbl[2]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
    tbl[3]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
    tbl[4]  = mk(0, 8'h00, 1, 0, 1, 1, 8'hA5, 1);
    tbl[5]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    tbl[6]  = mk(1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
    tbl[7]  = mk(1, 8'h02, 0, 0, 1, 0, 8'h00, 1);
    tbl[8]  = mk(1, 8'h03, 0, 0, 1, 0, 8'h00, 2);
    tbl[9]  = mk(1, 8'h04, 0, 0, 1, 0, 8'h00, 3);
    tbl[10] = mk(1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
    tbl[11] = mk(1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
    tbl[12] = mk(1, 8'h05, 1, 0, 1, 1, 8'h01, 4);
    tbl[13] = mk(1, 8'h06, 1, 0, 1, 1, 8'h02, 4);
    tbl[14] = mk(0, 8'h00, 1, 0, 1, 1, 8'h03, 4);
    tbl[15] = mk(0, 8'h00, 1, 0, 1, 1, 8'h04, 3);
    tbl[16] = mk(0, 8'h00, 1, 0, 1, 1, 8'h05, 2);
    tbl[17] = mk(0, 8'h00, 1, 0, 1, 1, 8'h06, 1);
    tbl[18] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

    rst = 1'b0; d = '0; d_valid = 1'b0; flush = 1'b0; q_ready = 1'b0;
    #2;
    chk("reset_q", 64'(q), 64'h0);
    chk("reset_q_valid", 64'(q_valid), 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_d_ready", 64'(d_ready), 64'h1);
    chk_qbar("reset_qbar");
    flush = 1'b1;
    #1;
    chk("reset_d_ready_flush", 64'(d_ready), 64'h0);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].dv, tbl[i].dd, tbl[i].qr, tbl[i].fl);
      chk($sformatf("tbl%0d_d_ready", i), 64'(d_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_q_valid", i), 64'(q_valid), 64'(tbl[i].e_qv));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      if (tbl[i].e_qv) begin
        chk($sformatf("tbl%0d_q", i), 64'(q), 64'(tbl[i].e_q));
        chk_qbar($sformatf("tbl%0d_qbar", i));
      end
    end

    // Bubble collapse: second beat slides up behind a stalled beat in stage 3.
    drive(1, 8'h3C, 0, 0);
    repeat (3) drive(0, 8'h00, 0, 0);
    drive(1, 8'hC3, 0, 0);
    chk("bub_q_valid", 64'(q_valid), 64'h1);
    chk("bub_q", 64'(q), 64'h3C);
    chk("bub_d_ready", 64'(d_ready), 64'h1);
    repeat (3) drive(0, 8'h00, 0, 0);
    chk("bub_count2", 64'(count), 64'h2);
    chk("bub_d_ready_gap", 64'(d_ready), 64'h1);
    drive(0, 8'h00, 1, 0);
    chk("bub_first_out", 64'(q), 64'h3C);
    drive(0, 8'h00, 1, 0);
    chk("bub_second_out", 64'(q), 64'hC3);
    chk("bub_second_valid", 64'(q_valid), 64'h1);
    chk("bub_count1", 64'(count), 64'h1);
    drive(0, 8'h00, 1, 0);
    chk("bub_count0", 64'(count), 64'h0);

    // Flush beats a simultaneous input beat and output consume.
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0);
    drive(1, 8'hEE, 1, 1);
    chk("fl_count3", 64'(count), 64'h3);
    chk("fl_d_ready", 64'(d_ready), 64'h0);
    drive(0, 8'h00, 1, 0);
    chk("fl_count0", 64'(count), 64'h0);
    chk("fl_q_valid", 64'(q_valid), 64'h0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 8'h00, 1, 0);
      chk($sformatf("fl_no_beat%0d", k), 64'(q_valid), 64'h0);
    end

    // Asynchronous reset in mid-stream, then fresh latency.
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h66, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("ar_count2", 64'(count), 64'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_q_valid", 64'(q_valid), 64'h0);
    chk("ar_count", 64'(count), 64'h0);
    chk("ar_q", 64'(q), 64'h0);
    chk("ar_d_ready", 64'(d_ready), 64'h1);
    chk_qbar("ar_qbar");
    @(negedge clk);
    rst = 1'b1;
    drive(1, 8'h77, 1, 0);
    chk("ar_first_d_ready", 64'(d_ready), 64'h1);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 8'h00, 1, 0);
      chk($sformatf("ar_lat%0d_q_valid", k), 64'(q_valid), (k == 4) ? 64'h1 : 64'h0);
    end
    chk("ar_lat_q", 64'(q), 64'h77);
    drive(0, 8'h00, 1, 0);
    chk("ar_drained", 64'(count), 64'h0);

    // Randomized run against the queue model; pipe is empty here.
    mq.delete();
    for (int seg = 0; seg < 4; seg++) begin
      for (int cyc = 0; cyc < 150; cyc++) begin
        r_dv = ($urandom_range(0, 3) != 0);
        r_qr = ($urandom_range(0, 3) <= seg);
        r_fl = ($urandom_range(0, 39) == 0);
        r_d  = WIDTH'($urandom);
        drive(r_dv, r_d, r_qr, r_fl);
        e_rdy = !r_fl && (model_free(r_qr) >= 0);
        e_qv  = (mq.size() > 0) && (mq[0].pos == STAGES - 1);
        chk("rnd_d_ready", 64'(d_ready), 64'(e_rdy));
        chk("rnd_q_valid", 64'(q_valid), 64'(e_qv));
        chk("rnd_count", 64'(count), 64'(mq.size()));
        if (e_qv) begin
          chk("rnd_q", 64'(q), 64'(mq[0].data));
          chk_qbar("rnd_qbar");
        end
        model_commit(r_dv, r_d, r_qr, r_fl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
